// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing one IPv4 transmit packetiser between NUM_REQ result producers.
// Latches the winner's request, strobes the packetiser, and frees itself on the last MAC beat or on watchdog expiry.
module ip_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int IP_ADDR_WIDTH  = 32,
    parameter int MAC_ADDR_WIDTH = 48,
    parameter int MSG_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int GRANT_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [NUM_REQ-1:0]                 REQ_VALID,
    output logic [NUM_REQ-1:0]                 REQ_READY,
    input  logic [NUM_REQ*IP_ADDR_WIDTH-1:0]   REQ_IP_ADDRESS,
    input  logic [NUM_REQ*MAC_ADDR_WIDTH-1:0]  REQ_MAC_ADDRESS,
    input  logic [NUM_REQ*MSG_WIDTH-1:0]       REQ_MESSAGE,
    output logic [IP_ADDR_WIDTH-1:0]           TX_RECIPIENT_IP_ADDRESS,
    output logic [MAC_ADDR_WIDTH-1:0]          TX_RECIPIENT_MAC_ADDRESS,
    output logic [MSG_WIDTH-1:0]               TX_RECIPIENT_MESSAGE,
    output logic                               TX_START_IP_TXN,
    input  logic                               TX_READY_FOR_SEND,
    input  logic                               TX_MAC_DATA_VALID,
    input  logic                               TX_MAC_DATA_READY,
    input  logic                               TX_MAC_DATA_LAST,
    output logic                               BUSY,
    output logic [GRANT_WIDTH-1:0]             GRANT_ID,
    output logic                               TXN_DONE,
    output logic                               TIMEOUT_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        IN_FLIGHT
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [GRANT_WIDTH-1:0] rr_ptr;
    logic [GRANT_WIDTH-1:0] winner;
    logic [GRANT_WIDTH-1:0] grant_inc;
    logic [GRANT_WIDTH:0]   scan_idx;
    logic [15:0]            wd_cnt;
    logic                   found;
    logic                   accept;
    logic                   last_beat;
    logic                   wd_expired;

    // Scan requesters starting at rr_ptr, wrapping, and keep the first valid one.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_ptr} + (GRANT_WIDTH+1)'(i);
            if (scan_idx >= (GRANT_WIDTH+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (GRANT_WIDTH+1)'(NUM_REQ);
            end
            if (!found && REQ_VALID[scan_idx[GRANT_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[GRANT_WIDTH-1:0];
            end
        end
    end

    // Gating with ARESET keeps the accept strobe low while reset is held.
    assign accept     = (state == IDLE) && found && TX_READY_FOR_SEND && !ARESET;
    assign REQ_READY  = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign last_beat  = TX_MAC_DATA_VALID && TX_MAC_DATA_READY && TX_MAC_DATA_LAST;
    assign wd_expired = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign grant_inc  = (GRANT_ID == GRANT_WIDTH'(NUM_REQ - 1)) ? '0 : GRANT_ID + GRANT_WIDTH'(1);
    assign BUSY       = (state != IDLE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        TX_START_IP_TXN = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                TX_START_IP_TXN = 1'b1;
                if (TX_READY_FOR_SEND) begin
                    state_next = IN_FLIGHT;
                end
            end
            IN_FLIGHT: begin
                if (last_beat || wd_expired) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A last beat coinciding with watchdog expiry is a normal completion.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            TX_RECIPIENT_IP_ADDRESS  <= '0;
            TX_RECIPIENT_MAC_ADDRESS <= '0;
            TX_RECIPIENT_MESSAGE     <= '0;
            GRANT_ID                 <= '0;
            rr_ptr                   <= '0;
            wd_cnt                   <= '0;
            TXN_DONE                 <= 1'b0;
            TIMEOUT_ERR              <= 1'b0;
        end else begin
            TXN_DONE <= 1'b0;
            if (accept) begin
                TX_RECIPIENT_IP_ADDRESS  <= REQ_IP_ADDRESS[winner*IP_ADDR_WIDTH +: IP_ADDR_WIDTH];
                TX_RECIPIENT_MAC_ADDRESS <= REQ_MAC_ADDRESS[winner*MAC_ADDR_WIDTH +: MAC_ADDR_WIDTH];
                TX_RECIPIENT_MESSAGE     <= REQ_MESSAGE[winner*MSG_WIDTH +: MSG_WIDTH];
                GRANT_ID                 <= winner;
            end
            if (state == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state == IN_FLIGHT) begin
                if (last_beat) begin
                    TXN_DONE <= 1'b1;
                    rr_ptr   <= grant_inc;
                    wd_cnt   <= '0;
                end else if (wd_expired) begin
                    TIMEOUT_ERR <= 1'b1;
                    rr_ptr      <= grant_inc;
                    wd_cnt      <= '0;
                end else if (wd_cnt != 16'hFFFF) begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Testbench for ip_tx_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ip_tx_arbiter;

    localparam int N    = 2;
    localparam int IPW  = 32;
    localparam int MACW = 48;
    localparam int MSGW = 10;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IPW-1:0]  req_ip;
    logic [N*MACW-1:0] req_mac;
    logic [N*MSGW-1:0] req_msg;
    logic [IPW-1:0]    tx_ip;
    logic [MACW-1:0]   tx_mac;
    logic [MSGW-1:0]   tx_msg;
    logic              tx_start;
    logic              tx_rfs;
    logic              mac_valid;
    logic              mac_ready;
    logic              mac_last;
    logic              busy;
    logic [0:0]        grant_id;
    logic              txn_done;
    logic              timeout_err;

    logic [IPW-1:0]    f_ip  [N];
    logic [MACW-1:0]   f_mac [N];
    logic [MSGW-1:0]   f_msg [N];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_ip[g*IPW +: IPW]    = f_ip[g];
        assign req_mac[g*MACW +: MACW] = f_mac[g];
        assign req_msg[g*MSGW +: MSGW] = f_msg[g];
    end

    ip_tx_arbiter #(
        .NUM_REQ(N), .IP_ADDR_WIDTH(IPW), .MAC_ADDR_WIDTH(MACW),
        .MSG_WIDTH(MSGW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .ACLK(clk), .ARESET(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_IP_ADDRESS(req_ip), .REQ_MAC_ADDRESS(req_mac), .REQ_MESSAGE(req_msg),
        .TX_RECIPIENT_IP_ADDRESS(tx_ip), .TX_RECIPIENT_MAC_ADDRESS(tx_mac),
        .TX_RECIPIENT_MESSAGE(tx_msg), .TX_START_IP_TXN(tx_start),
        .TX_READY_FOR_SEND(tx_rfs), .TX_MAC_DATA_VALID(mac_valid),
        .TX_MAC_DATA_READY(mac_ready), .TX_MAC_DATA_LAST(mac_last),
        .BUSY(busy), .GRANT_ID(grant_id), .TXN_DONE(txn_done), .TIMEOUT_ERR(timeout_err)
    );

    function automatic int model_pick(logic [N-1:0] v, int rr);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int w);
        logic [N-1:0] r;
        r = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    task automatic clear_inputs();
        req_valid = '0;
        tx_rfs    = 1'b0;
        mac_valid = 1'b0;
        mac_ready = 1'b0;
        mac_last  = 1'b0;
        for (int k = 0; k < N; k++) begin
            f_ip[k]  = '0;
            f_mac[k] = '0;
            f_msg[k] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic randomize_req(int k);
        f_ip[k]  = $urandom();
        f_mac[k] = 48'({$urandom(), $urandom()});
        f_msg[k] = 10'($urandom());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req_valid = '1;
        tx_rfs    = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== '0) $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (tx_start !== 1'b0) $display("[TB] FAIL reset_start: got %b expected 0", tx_start); else passes++;
        checks++; if ({txn_done, timeout_err, grant_id} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {txn_done, timeout_err, grant_id}); else passes++;
        checks++; if ({tx_ip, tx_mac, tx_msg} !== '0) $display("[TB] FAIL reset_tx: got %h expected 0", {tx_ip, tx_mac, tx_msg}); else passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        int done_seen;
        do_reset();
        f_ip[0]   = 32'h0A000002;
        f_mac[0]  = 48'h001122334455;
        f_msg[0]  = 10'h2A5;
        req_valid = 2'b01;
        tx_rfs    = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) $display("[TB] FAIL single_ready: got %b expected 01", req_ready); else passes++;
        checks++; if (tx_start !== 1'b0) $display("[TB] FAIL single_start_early: got %b expected 0", tx_start); else passes++;
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (tx_start !== 1'b1) $display("[TB] FAIL single_start: got %b expected 1", tx_start); else passes++;
        checks++; if (tx_ip !== 32'h0A000002) $display("[TB] FAIL single_ip: got %h expected 0a000002", tx_ip); else passes++;
        checks++; if (tx_mac !== 48'h001122334455) $display("[TB] FAIL single_mac: got %h expected 001122334455", tx_mac); else passes++;
        checks++; if (tx_msg !== 10'h2A5) $display("[TB] FAIL single_msg: got %h expected 2a5", tx_msg); else passes++;
        next_cycle();
        done_seen = 0;
        for (int b = 0; b < 64; b++) begin
            mac_valid = 1'b1;
            mac_ready = 1'b1;
            mac_last  = (b == 63);
            @(negedge clk);
            if (b == 0) begin
                checks++; if (tx_start !== 1'b0) $display("[TB] FAIL single_start_len: got %b expected 0", tx_start); else passes++;
            end
            if (txn_done === 1'b1) done_seen++;
            next_cycle();
        end
        mac_valid = 1'b0;
        mac_last  = 1'b0;
        @(negedge clk);
        checks++; if (txn_done !== 1'b1) $display("[TB] FAIL single_done: got %b expected 1", txn_done); else passes++;
        checks++; if (done_seen != 0) $display("[TB] FAIL single_early_done: got %0d expected 0", done_seen); else passes++;
        checks++; if (grant_id !== 1'b0) $display("[TB] FAIL single_grant: got %b expected 0", grant_id); else passes++;
        checks++; if ({busy, timeout_err} !== 2'b00) $display("[TB] FAIL single_idle: got %b expected 00", {busy, timeout_err}); else passes++;
        checks++; if (tx_ip !== 32'h0A000002) $display("[TB] FAIL single_ip_hold: got %h expected 0a000002", tx_ip); else passes++;
        next_cycle();
        @(negedge clk);
        checks++; if (txn_done !== 1'b0) $display("[TB] FAIL single_done_len: got %b expected 0", txn_done); else passes++;
        next_cycle();
    endtask

    task automatic test_contention();
        int exp_g;
        int cnt0;
        int cnt1;
        logic [IPW-1:0] e_ip;
        do_reset();
        randomize_req(0);
        randomize_req(1);
        req_valid = 2'b11;
        tx_rfs    = 1'b1;
        exp_g = 0;
        cnt0  = 0;
        cnt1  = 0;
        for (int fr = 0; fr < 4; fr++) begin
            @(negedge clk);
            checks++; if (req_ready !== onehot(exp_g)) $display("[TB] FAIL contention_ready: frame %0d got %b expected %b", fr, req_ready, onehot(exp_g)); else passes++;
            if (req_ready[0] === 1'b1) cnt0++;
            if (req_ready[1] === 1'b1) cnt1++;
            e_ip = f_ip[exp_g];
            next_cycle();
            randomize_req(exp_g);
            @(negedge clk);
            checks++; if (grant_id !== 1'(exp_g)) $display("[TB] FAIL contention_grant: frame %0d got %0d expected %0d", fr, grant_id, exp_g); else passes++;
            checks++; if (tx_ip !== e_ip) $display("[TB] FAIL contention_ip: frame %0d got %h expected %h", fr, tx_ip, e_ip); else passes++;
            if (req_ready[0] === 1'b1) cnt0++;
            if (req_ready[1] === 1'b1) cnt1++;
            next_cycle();
            for (int b = 0; b < 3; b++) begin
                mac_valid = 1'b1;
                mac_ready = 1'b1;
                mac_last  = (b == 2);
                @(negedge clk);
                if (req_ready[0] === 1'b1) cnt0++;
                if (req_ready[1] === 1'b1) cnt1++;
                next_cycle();
            end
            mac_valid = 1'b0;
            mac_last  = 1'b0;
            exp_g = (exp_g + 1) % N;
        end
        req_valid = '0;
        checks++; if (cnt0 != 2) $display("[TB] FAIL contention_count0: got %0d expected 2", cnt0); else passes++;
        checks++; if (cnt1 != 2) $display("[TB] FAIL contention_count1: got %0d expected 2", cnt1); else passes++;
    endtask

    task automatic test_not_ready();
        int start_cnt;
        int extra;
        int stray_ready;
        logic [IPW+MACW+MSGW-1:0] e_tx;
        do_reset();
        randomize_req(1);
        req_valid = 2'b10;
        tx_rfs    = 1'b1;
        e_tx = {f_ip[1], f_mac[1], f_msg[1]};
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) $display("[TB] FAIL notready_accept: got %b expected 10", req_ready); else passes++;
        next_cycle();
        randomize_req(0);
        randomize_req(1);
        req_valid   = 2'b01;
        tx_rfs      = 1'b0;
        start_cnt   = 0;
        stray_ready = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) tx_rfs = 1'b1;
            @(negedge clk);
            if (tx_start === 1'b1) start_cnt++;
            if (req_ready !== '0) stray_ready++;
            checks++; if ({tx_ip, tx_mac, tx_msg} !== e_tx) $display("[TB] FAIL notready_tx_hold: cycle %0d got %h expected %h", c, {tx_ip, tx_mac, tx_msg}, e_tx); else passes++;
            next_cycle();
        end
        checks++; if (start_cnt != 6) $display("[TB] FAIL notready_start_len: got %0d expected 6", start_cnt); else passes++;
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            tx_rfs = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tx_start === 1'b1 || busy !== 1'b1) extra++;
            if (req_ready !== '0) stray_ready++;
            next_cycle();
        end
        checks++; if (extra != 0) $display("[TB] FAIL notready_single_transition: got %0d bad cycles expected 0", extra); else passes++;
        checks++; if (stray_ready != 0) $display("[TB] FAIL notready_busy_ready: got %0d strobes expected 0", stray_ready); else passes++;
        tx_rfs    = 1'b1;
        mac_valid = 1'b1;
        mac_ready = 1'b1;
        mac_last  = 1'b1;
        @(negedge clk);
        next_cycle();
        mac_valid = 1'b0;
        mac_last  = 1'b0;
        @(negedge clk);
        checks++; if (txn_done !== 1'b1) $display("[TB] FAIL notready_done: got %b expected 1", txn_done); else passes++;
        checks++; if (req_ready !== 2'b01) $display("[TB] FAIL notready_waiting_req: got %b expected 01", req_ready); else passes++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int rr, grant, fl_cycles, beats_left, w, frames, done_count;
        bit busy_m, launch_m, flight_m, done_m, err_m, last_held;
        logic [N-1:0] pend;
        logic [N-1:0] exp_ready;
        logic [IPW+MACW+MSGW-1:0] e_tx;
        do_reset();
        rr = 0; grant = 0; fl_cycles = 0; beats_left = 0; frames = 0; done_count = 0;
        busy_m = 0; launch_m = 0; flight_m = 0; done_m = 0; err_m = 0; last_held = 0;
        pend = '0;
        e_tx = '0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 99) < 30) begin
                    pend[k] = 1'b1;
                    randomize_req(k);
                end else if (pend[k] && $urandom_range(0, 99) < 4) begin
                    pend[k] = 1'b0;
                end
            end
            req_valid = pend;
            tx_rfs    = ($urandom_range(0, 99) < 75);
            if (flight_m) begin
                mac_valid = ($urandom_range(0, 99) < 70) || (fl_cycles > 40);
                mac_last  = mac_valid && (beats_left == 1);
                mac_ready = ($urandom_range(0, 1) == 1) || (fl_cycles > 40);
                if (mac_last && !last_held) begin
                    mac_ready = 1'b0;
                    last_held = 1'b1;
                end
            end else begin
                mac_valid = 1'($urandom_range(0, 1));
                mac_ready = 1'($urandom_range(0, 1));
                mac_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            w = model_pick(req_valid, rr);
            exp_ready = (!busy_m && tx_rfs && w >= 0) ? onehot(w) : '0;
            checks++; if (req_ready !== exp_ready) $display("[TB] FAIL bp_ready: cycle %0d got %b expected %b", c, req_ready, exp_ready); else passes++;
            checks++; if (tx_start !== launch_m) $display("[TB] FAIL bp_start: cycle %0d got %b expected %b", c, tx_start, launch_m); else passes++;
            checks++; if (busy !== busy_m) $display("[TB] FAIL bp_busy: cycle %0d got %b expected %b", c, busy, busy_m); else passes++;
            checks++; if (txn_done !== done_m) $display("[TB] FAIL bp_done: cycle %0d got %b expected %b", c, txn_done, done_m); else passes++;
            checks++; if (timeout_err !== err_m) $display("[TB] FAIL bp_timeout_err: cycle %0d got %b expected %b", c, timeout_err, err_m); else passes++;
            checks++; if (grant_id !== 1'(grant)) $display("[TB] FAIL bp_grant: cycle %0d got %0d expected %0d", c, grant_id, grant); else passes++;
            checks++; if ({tx_ip, tx_mac, tx_msg} !== e_tx) $display("[TB] FAIL bp_tx: cycle %0d got %h expected %h", c, {tx_ip, tx_mac, tx_msg}, e_tx); else passes++;
            done_m = 1'b0;
            if (!busy_m) begin
                if (exp_ready != '0) begin
                    busy_m   = 1'b1;
                    launch_m = 1'b1;
                    grant    = w;
                    e_tx     = {f_ip[w], f_mac[w], f_msg[w]};
                    pend[w]  = 1'b0;
                    frames++;
                end
            end else if (launch_m) begin
                if (tx_rfs) begin
                    launch_m   = 1'b0;
                    flight_m   = 1'b1;
                    fl_cycles  = 0;
                    beats_left = $urandom_range(1, 6);
                    last_held  = 1'b0;
                end
            end else begin
                if (mac_valid && mac_ready && mac_last) begin
                    done_m   = 1'b1;
                    busy_m   = 1'b0;
                    flight_m = 1'b0;
                    rr       = (grant + 1) % N;
                    done_count++;
                end else if (fl_cycles == TMO - 1) begin
                    err_m    = 1'b1;
                    busy_m   = 1'b0;
                    flight_m = 1'b0;
                    rr       = (grant + 1) % N;
                end else begin
                    fl_cycles++;
                    if (mac_valid && mac_ready) beats_left--;
                end
            end
            next_cycle();
        end
        checks++; if (done_count < 10) $display("[TB] FAIL bp_traffic: got %0d completed frames expected at least 10", done_count); else passes++;
        clear_inputs();
    endtask

    task automatic test_timeout();
        int done_cnt, not_busy, stray_ready;
        logic [IPW-1:0] e_ip;
        do_reset();
        randomize_req(0);
        req_valid = 2'b01;
        tx_rfs    = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) $display("[TB] FAIL timeout_accept: got %b expected 01", req_ready); else passes++;
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        next_cycle();
        randomize_req(0);
        randomize_req(1);
        e_ip = f_ip[1];
        done_cnt = 0; not_busy = 0; stray_ready = 0;
        for (int c = 0; c < 64; c++) begin
            req_valid = 2'b11;
            mac_valid = 1'($urandom_range(0, 1));
            mac_ready = 1'($urandom_range(0, 1));
            mac_last  = 1'b0;
            @(negedge clk);
            if (busy !== 1'b1) not_busy++;
            if (txn_done === 1'b1) done_cnt++;
            if (req_ready !== '0) stray_ready++;
            if (c == 63) begin
                checks++; if (timeout_err !== 1'b0) $display("[TB] FAIL timeout_err_early: got %b expected 0", timeout_err); else passes++;
            end
            next_cycle();
        end
        mac_valid = 1'b0;
        mac_ready = 1'b0;
        @(negedge clk);
        checks++; if (not_busy != 0) $display("[TB] FAIL timeout_busy_span: got %0d idle cycles expected 0", not_busy); else passes++;
        checks++; if (stray_ready != 0) $display("[TB] FAIL timeout_busy_ready: got %0d strobes expected 0", stray_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL timeout_idle: got %b expected 0", busy); else passes++;
        checks++; if (timeout_err !== 1'b1) $display("[TB] FAIL timeout_err: got %b expected 1", timeout_err); else passes++;
        checks++; if ({txn_done, 32'(done_cnt)} !== 33'd0) $display("[TB] FAIL timeout_no_done: got %b/%0d expected 0/0", txn_done, done_cnt); else passes++;
        checks++; if (req_ready !== 2'b10) $display("[TB] FAIL timeout_next_ready: got %b expected 10", req_ready); else passes++;
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if (grant_id !== 1'b1) $display("[TB] FAIL timeout_next_grant: got %b expected 1", grant_id); else passes++;
        checks++; if (tx_ip !== e_ip) $display("[TB] FAIL timeout_next_ip: got %h expected %h", tx_ip, e_ip); else passes++;
        next_cycle();
        mac_valid = 1'b1;
        mac_ready = 1'b1;
        mac_last  = 1'b1;
        @(negedge clk);
        next_cycle();
        mac_valid = 1'b0;
        mac_last  = 1'b0;
        @(negedge clk);
        checks++; if ({txn_done, timeout_err} !== 2'b11) $display("[TB] FAIL timeout_sticky: got %b expected 11", {txn_done, timeout_err}); else passes++;
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_mid_flight();
        logic [IPW-1:0] e_ip;
        do_reset();
        randomize_req(0);
        req_valid = 2'b01;
        tx_rfs    = 1'b1;
        @(negedge clk);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            mac_valid = 1'b1;
            mac_ready = 1'b1;
            mac_last  = 1'b0;
            @(negedge clk);
            next_cycle();
        end
        checks++; if (busy !== 1'b1) $display("[TB] FAIL rstmid_pre_busy: got %b expected 1", busy); else passes++;
        req_valid = 2'b11;
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, tx_start, txn_done, timeout_err, grant_id} !== 5'b0) $display("[TB] FAIL rstmid_flags: got %b expected 00000", {busy, tx_start, txn_done, timeout_err, grant_id}); else passes++;
        checks++; if (req_ready !== '0) $display("[TB] FAIL rstmid_ready: got %b expected 0", req_ready); else passes++;
        checks++; if ({tx_ip, tx_mac, tx_msg} !== '0) $display("[TB] FAIL rstmid_tx: got %h expected 0", {tx_ip, tx_mac, tx_msg}); else passes++;
        mac_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        randomize_req(1);
        e_ip = f_ip[1];
        req_valid = 2'b10;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) $display("[TB] FAIL rstmid_ready_after: got %b expected 10", req_ready); else passes++;
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++; if ({grant_id, tx_start} !== 2'b11) $display("[TB] FAIL rstmid_grant: got %b expected 11", {grant_id, tx_start}); else passes++;
        checks++; if (tx_ip !== e_ip) $display("[TB] FAIL rstmid_ip: got %h expected %h", tx_ip, e_ip); else passes++;
        next_cycle();
        mac_valid = 1'b1;
        mac_ready = 1'b1;
        mac_last  = 1'b1;
        @(negedge clk);
        next_cycle();
        mac_valid = 1'b0;
        mac_last  = 1'b0;
        @(negedge clk);
        checks++; if (txn_done !== 1'b1) $display("[TB] FAIL rstmid_done: got %b expected 1", txn_done); else passes++;
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "[TB] time limit expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_not_ready();
        test_backpressure();
        test_timeout();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
